// File: rtl/pkt_framer.sv
// Transmit packet framer: buffers CPU payload bytes and serialises preamble,
// sync word, length, payload and CRC-16 one bit per modulator strobe.
module pkt_framer #(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PREAMBLE_LEN = 4,
   parameter logic [15:0] SYNC_WORD    = 16'hD391
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   input  logic       start,
   output logic       busy,
   input  logic       bit_en,
   output logic       tx_bit,
   output logic       tx_valid,
   output logic       done
);

   localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W         = PTR_W + 1;
   localparam logic [15:0] CRC_POLY      = 16'h1021;
   localparam logic [15:0] CRC_INIT      = 16'hFFFF;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
   localparam logic [7:0]  LAST_PRE_IDX  = 8'(PREAMBLE_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_LEN,
      ST_PAYLOAD,
      ST_CRC
   } state_e;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q;
   logic             push;
   logic             pop;
   logic [7:0]       fifo_head;

   // ---------------------------------------------------------------- framer
   state_e      state_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  byte_cnt_q;
   logic [7:0]  len_q;
   logic [15:0] crc_q;
   logic        busy_q;
   logic        tx_valid_q;
   logic        done_q;

   logic        start_ok;
   logic        step;
   logic        byte_end;
   logic        last_payload;
   logic        crc_fb;
   logic [15:0] crc_next;

   assign fifo_head = mem_q[rd_ptr_q];

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      push         = wr_en && !full_q;
      start_ok     = (state_q == ST_IDLE) && start && (count_q != '0);
      step         = bit_en && (state_q != ST_IDLE);
      byte_end     = step && (bit_cnt_q == 3'd7);
      last_payload = (byte_cnt_q == len_q - 8'd1);
      pop          = byte_end &&
                     ((state_q == ST_LEN) || ((state_q == ST_PAYLOAD) && !last_payload));

      crc_fb   = crc_q[15] ^ shift_q[7];
      crc_next = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
      end
   end

   // NOTE: the storage array is deliberately not reset; clearing the pointers
   // and count empties the FIFO and keeps the array mappable to RAM.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 8'd0;
         len_q      <= 8'd0;
         crc_q      <= 16'h0000;
         busy_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_ok) begin
            state_q    <= ST_PREAMBLE;
            shift_q    <= PREAMBLE_BYTE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            len_q      <= 8'(count_q);
            crc_q      <= CRC_INIT;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
         end else if (step) begin
            // CRC covers payload bits only, folded in as each one is consumed.
            if (state_q == ST_PAYLOAD) crc_q <= crc_next;
            if (!byte_end) begin
               shift_q   <= {shift_q[6:0], 1'b0};
               bit_cnt_q <= bit_cnt_q + 3'd1;
            end else begin
               bit_cnt_q <= 3'd0;
               unique case (state_q)
                  ST_PREAMBLE: begin
                     if (byte_cnt_q == LAST_PRE_IDX) begin
                        state_q    <= ST_SYNC;
                        byte_cnt_q <= 8'd0;
                        shift_q    <= SYNC_WORD[15:8];
                     end else begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                        shift_q    <= PREAMBLE_BYTE;
                     end
                  end
                  ST_SYNC: begin
                     if (byte_cnt_q == 8'd0) begin
                        byte_cnt_q <= 8'd1;
                        shift_q    <= SYNC_WORD[7:0];
                     end else begin
                        state_q    <= ST_LEN;
                        byte_cnt_q <= 8'd0;
                        shift_q    <= len_q;
                     end
                  end
                  ST_LEN: begin
                     state_q    <= ST_PAYLOAD;
                     byte_cnt_q <= 8'd0;
                     shift_q    <= fifo_head;
                  end
                  ST_PAYLOAD: begin
                     if (last_payload) begin
                        // High CRC byte must include the bit consumed now.
                        state_q    <= ST_CRC;
                        byte_cnt_q <= 8'd0;
                        shift_q    <= crc_next[15:8];
                     end else begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                        shift_q    <= fifo_head;
                     end
                  end
                  ST_CRC: begin
                     if (byte_cnt_q == 8'd0) begin
                        byte_cnt_q <= 8'd1;
                        shift_q    <= crc_q[7:0];
                     end else begin
                        state_q    <= ST_IDLE;
                        byte_cnt_q <= 8'd0;
                        shift_q    <= 8'h00;
                        busy_q     <= 1'b0;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                     end
                  end
                  default: begin
                     state_q    <= ST_IDLE;
                     shift_q    <= 8'h00;
                     busy_q     <= 1'b0;
                     tx_valid_q <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign full     = full_q;
   assign busy     = busy_q;
   assign tx_bit   = shift_q[7];
   assign tx_valid = tx_valid_q;
   assign done     = done_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Randomised bench for pkt_framer: a queue-based frame model predicts every
// serial byte, the LEN field and the CRC, and the stream is compared against it.
module tb_pkt_framer;

   localparam int DEPTH = 16;
   localparam int PRE   = 4;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       wr_en    = 1'b0;
   logic [7:0] wr_data  = 8'h00;
   logic       start    = 1'b0;
   logic       bit_en   = 1'b0;
   logic       full;
   logic       busy;
   logic       tx_bit;
   logic       tx_valid;
   logic       done;

   int total_cnt = 0;
   int bad_cnt   = 0;
   logic [7:0] model_fifo[$];

   always #5 clk = ~clk;

   pkt_framer #(
      .FIFO_DEPTH  (DEPTH),
      .PREAMBLE_LEN(PRE),
      .SYNC_WORD   (16'hD391)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .start   (start),
      .busy    (busy),
      .bit_en  (bit_en),
      .tx_bit  (tx_bit),
      .tx_valid(tx_valid),
      .done    (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] crc16(input logic [7:0] data[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (data[i]) begin
         for (int b = 7; b >= 0; b--) begin
            if (c[15] ^ data[i][b]) c = (c << 1) ^ 16'h1021;
            else                    c = c << 1;
         end
      end
      return c;
   endfunction

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic run_packet(input int period, input bit extra_start, input bit mid_write,
                             input logic [7:0] mid_byte, input string name);
      logic [7:0] exp[$];
      logic [7:0] pay[$];
      logic       got[$];
      logic [15:0] c;
      logic [7:0] v;
      logic       prev_bit;
      bit         prev_stb;
      int len, total, nstb, ncyc, dones, hold_err, write_at;
      len      = model_fifo.size();
      nstb     = 0;
      ncyc     = 0;
      dones    = 0;
      hold_err = 0;
      write_at = period * (8 * (PRE + 3) + 12);
      for (int i = 0; i < PRE; i++) exp.push_back(8'hAA);
      exp.push_back(8'hD3);
      exp.push_back(8'h91);
      exp.push_back(8'(len));
      for (int i = 0; i < len; i++) pay.push_back(model_fifo.pop_front());
      foreach (pay[i]) exp.push_back(pay[i]);
      c = crc16(pay);
      exp.push_back(c[15:8]);
      exp.push_back(c[7:0]);
      total = 8 * exp.size();

      start = 1'b1;
      cyc();
      start = 1'b0;
      check({name, ".start"}, 32'({busy, tx_valid, tx_bit}), 32'h7);

      prev_bit = tx_bit;
      prev_stb = 1'b0;
      while (nstb < total && ncyc < total * period + 50) begin
         if (done) dones++;
         if (!tx_valid) hold_err++;
         if (!prev_stb && tx_bit !== prev_bit) hold_err++;
         prev_bit = tx_bit;
         bit_en   = ((ncyc % period) == period - 1);
         if (bit_en) begin
            got.push_back(tx_bit);
            nstb++;
         end
         prev_stb = bit_en;
         start    = extra_start && (ncyc == 20);
         wr_en    = mid_write && (ncyc == write_at);
         wr_data  = mid_byte;
         if (wr_en && model_fifo.size() < DEPTH) model_fifo.push_back(mid_byte);
         cyc();
         ncyc++;
      end
      bit_en = 1'b0;
      start  = 1'b0;
      wr_en  = 1'b0;

      check({name, ".strobes"}, 32'(nstb), 32'(total));
      check({name, ".end"}, 32'({done, busy, tx_valid, tx_bit}), 32'h8);
      check({name, ".early_done"}, 32'(dones), 32'd0);
      check({name, ".stream_hold"}, 32'(hold_err), 32'd0);
      for (int i = 0; i < exp.size(); i++) begin
         v = 8'hxx;
         if (8 * i + 7 < got.size())
            for (int b = 0; b < 8; b++) v = {v[6:0], got[8 * i + b]};
         check($sformatf("%s.byte%0d", name, i), 32'(v), 32'(exp[i]));
      end
      cyc();
      check({name, ".done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int dones;

      // Reset held with random activity on every input.
      for (int i = 0; i < 5; i++) begin
         wr_en   = 1'($urandom);
         wr_data = 8'($urandom);
         start   = 1'($urandom);
         bit_en  = 1'($urandom);
         cyc();
         check("reset_outs", 32'({full, busy, tx_bit, tx_valid, done}), 32'h0);
      end
      wr_en  = 1'b0;
      start  = 1'b0;
      bit_en = 1'b0;
      reset  = 1'b1;
      cyc();
      check("post_reset_outs", 32'({full, busy, tx_bit, tx_valid, done}), 32'h0);

      // Start with an empty FIFO must be ignored.
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("empty_start", 32'({busy, tx_valid}), 32'h0);
      cyc();
      check("empty_start_done", 32'(done), 32'd0);

      // Golden packet with a stray start and a mid-payload write.
      for (int i = 0; i < 9; i++) write_byte(8'h31 + 8'(i));
      run_packet(4, 1'b1, 1'b1, 8'hA5, "golden");
      run_packet(int'($urandom_range(1, 4)), 1'b0, 1'b0, 8'h00, "a5");

      // Overfill the FIFO.
      for (int i = 0; i < 17; i++) begin
         write_byte(8'(i));
         if (i == 14) check("full_at15", 32'(full), 32'd0);
         if (i >= 15) check($sformatf("full_at%0d", i + 1), 32'(full), 32'd1);
      end
      run_packet(2, 1'b0, 1'b0, 8'h00, "full");
      check("full_cleared", 32'(full), 32'd0);

      // Reset in the middle of the payload.
      for (int i = 0; i < 9; i++) write_byte(8'h31 + 8'(i));
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 2 * (8 * (PRE + 3) + 20); i++) begin
         bit_en = (i % 2 == 1);
         cyc();
      end
      bit_en = 1'b0;
      reset  = 1'b0;
      cyc();
      check("midrst_outs", 32'({full, busy, tx_bit, tx_valid, done}), 32'h0);
      reset = 1'b1;
      model_fifo.delete();
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (done) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("midrst_fifo_empty", 32'({busy, tx_valid}), 32'h0);
      cyc();
      for (int i = 0; i < 9; i++) write_byte(8'h31 + 8'(i));
      run_packet(4, 1'b0, 1'b0, 8'h00, "golden2");

      // Random payloads and strobe rates.
      for (int k = 0; k < 6; k++) begin
         int n;
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) write_byte(8'($urandom));
         run_packet(int'($urandom_range(1, 5)), 1'($urandom), 1'b0, 8'h00,
                    $sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/pkt_framer.md
# pkt_framer

Transmit packet framer that sits directly upstream of the FSK modulator in the transceiver (txrx) path of each SoC. The CPU writes payload bytes into an internal FIFO and issues a start command. The block then emits a serial bitstream of preamble, sync word, length, payload and CRC-16, advancing one bit per bit-rate strobe from the modulator. The modulator drives the antenna from this stream.

## Interface

Parameters:
- `FIFO_DEPTH`, default 16: payload FIFO depth in bytes; power of two, max 128.
- `PREAMBLE_LEN`, default 4: number of 0xAA preamble bytes; 1..15.
- `SYNC_WORD`, default 16'hD391: sync word, sent MSB first.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset; 0 = reset, sampled on rising `clk`.
- `wr_en`  in  1  write `wr_data` into payload FIFO this cycle.
- `wr_data`  in  8  payload byte.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `start`  in  1  single-cycle request to transmit the current FIFO contents.
- `busy`  out  1  packet in progress.
- `bit_en`  in  1  one-cycle bit-period strobe from the modulator.
- `tx_bit`  out  1  current serial bit, to the modulator.
- `tx_valid`  out  1  `tx_bit` is meaningful; modulator keys the carrier while high.
- `done`  out  1  one-cycle pulse at end of packet.

## Operation

- Frame format, every byte MSB first:
  - `PREAMBLE_LEN` x 0xAA
  - `SYNC_WORD` (2 bytes)
  - LEN (1 byte): FIFO count latched at start
  - LEN payload bytes
  - CRC (2 bytes)
- CRC:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed bit-serially over payload bits only, as they are shifted out.
- FSM states: IDLE -> PREAMBLE -> SYNC -> LEN -> PAYLOAD -> CRC -> IDLE.
  - Byte counter and 3-bit bit counter track position within each state.
  - A 8-bit shift register holds the current byte; `tx_bit` = shift register MSB.
- Start handling:
  - `start` is accepted only in IDLE with FIFO count > 0.
  - `start` with an empty FIFO is ignored: no packet, no `done`.
  - `start` while `busy` is ignored.
- FIFO and payload:
  - The payload byte is popped from the FIFO when it is loaded into the shift register, at the transition into its first bit.
  - Writes are accepted in any state while not full. Writes made during a packet are kept for the next packet; they are not counted in the latched LEN.
  - A write while `full` is dropped with no side effects.
  - Simultaneous write and pop: count unchanged, both take effect.
- `bit_en`:
  - Ignored in IDLE.
  - A `bit_en` on the same cycle `start` is accepted is ignored.
- Reset:
  - Assertion at any time returns the FSM to IDLE, flushes the FIFO, clears the CRC and drops `tx_valid` on the next edge. No `done` is emitted.
- Reset values: `full`=0, `busy`=0, `tx_bit`=0, `tx_valid`=0, `done`=0.

## Timing

- Start latency: on the cycle after `start` is accepted:
  - `busy`=1, `tx_valid`=1.
  - `tx_bit` = first preamble bit (1).
  - LEN is latched.
- Bit advance: each `bit_en` while busy moves `tx_bit` to the next frame bit on the following cycle. Between strobes, `tx_bit` is held stable.
- Packet length: total bits = 8 x (`PREAMBLE_LEN` + 5 + LEN). `bit_en` strobes consumed = the same count.
- End of packet: on the `bit_en` that consumes the last CRC bit, the next cycle has:
  - `tx_valid`=0, `busy`=0, `tx_bit`=0
  - `done`=1 for exactly one cycle
  - state IDLE
- Back-to-back packets: a new `start` is accepted on the same cycle `done` is high.
- Status latency: `full` is registered and updates the cycle after the write or pop that changes the count.

## Test plan

- Reset check: hold `reset`=0 for 5 cycles with random `wr_en`/`start`/`bit_en` -> all outputs 0, FIFO empty afterwards.
- Golden packet:
  - Stimulus: write 0x31..0x39 ("123456789"), pulse `start`, `bit_en` every 4 cycles.
  - Required: serial bytes AA AA AA AA D3 91 09 31 32 33 34 35 36 37 38 39 29 B1; 144 bits total; one `done` pulse one cycle after the 144th strobe.
- FIFO full:
  - Stimulus: write 17 bytes 0x00..0x10.
  - Required: `full`=1 after the 16th; 0x10 dropped; LEN byte 0x10; payload 0x00..0x0F.
- Ignored starts:
  - Stimulus: `start` with an empty FIFO; then, during the golden packet, `start` again.
  - Required: empty-FIFO start leaves `busy`=0, `tx_valid`=0; second start has no effect on the stream; exactly one `done`.
- Writes during packet:
  - Stimulus: write 0xA5 mid-payload of the golden packet.
  - Required: packet unchanged; a following `start` sends LEN 0x01, payload A5, and the CRC-16 of that single byte.
- Reset mid-packet:
  - Stimulus: assert `reset` during the PAYLOAD state.
  - Required: `tx_valid`=0 on the next edge; no `done`; FIFO empty; a subsequent golden packet is bit-exact.
